// File: rtl/spi_cmd_master_pkg.sv
// spi_cmd_pkg: opcodes and FSM encodings shared by the SPI command master.
package spi_cmd_pkg;
  localparam logic [7:0] CMD_WRITE = 8'h01;
  localparam logic [7:0] CMD_READ  = 8'h02;
  typedef enum logic [2:0] {S_WAIT, S_FETCH, S_PARSE, S_TGT_WR, S_TGT_RD, S_TX_LOAD} state_t;
  typedef enum logic [1:0] {P_CMD, P_ADDR, P_DATA, P_RESP} phase_t;
endpackage

// File: rtl/spi_cmd_master_if.sv
// spi_cmd_master_if: Wishbone master bus bundle shared by the command master and the system bus.
interface spi_cmd_master_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic [ADDR_WIDTH-1:0] wbm_address;
  logic [DATA_WIDTH-1:0] wbm_writedata;
  logic [DATA_WIDTH-1:0] wbm_readdata;
  logic                  wbm_strobe;
  logic                  wbm_cycle;
  logic                  wbm_write;
  logic                  wbm_ack;
  modport master (
    output wbm_address, wbm_writedata, wbm_strobe, wbm_cycle, wbm_write,
    input  wbm_readdata, wbm_ack
  );
  modport slave (
    input  wbm_address, wbm_writedata, wbm_strobe, wbm_cycle, wbm_write,
    output wbm_readdata, wbm_ack
  );
endinterface

// File: rtl/spi_cmd_master_wb_master_port.sv
// wb_master_port: registered WB strobe/ack handshake with ack timeout; relaunch only from an idle cycle.
module wb_master_port #(
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 32,
  parameter int ACK_TIMEOUT = 255
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_i,
  input  logic                  we_i,
  input  logic [ADDR_WIDTH-1:0] addr_i,
  input  logic [DATA_WIDTH-1:0] data_i,
  output logic                  done_o,
  output logic                  timeout_o,
  spi_cmd_master_if.master      bus
);
  localparam int TW = $clog2(ACK_TIMEOUT + 1);
  logic                  stb_q, we_q;
  logic [TW-1:0]         cnt_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] data_q;
  assign done_o            = stb_q & bus.wbm_ack;
  assign timeout_o         = stb_q & ~bus.wbm_ack & (cnt_q == TW'(ACK_TIMEOUT - 1));
  assign bus.wbm_strobe    = stb_q;
  assign bus.wbm_cycle     = stb_q;
  assign bus.wbm_write     = we_q;
  assign bus.wbm_address   = addr_q;
  assign bus.wbm_writedata = data_q;
  // A launch is only taken while strobe is low, so every transaction is followed by an idle cycle
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      stb_q  <= 1'b0;
      we_q   <= 1'b0;
      cnt_q  <= '0;
      addr_q <= '0;
      data_q <= '0;
    end else if (!stb_q) begin
      stb_q <= req_i;
      cnt_q <= '0;
      if (req_i) begin
        we_q   <= we_i;
        addr_q <= addr_i;
        data_q <= data_i;
      end
    end else begin
      stb_q <= ~(done_o | timeout_o);
      we_q  <= we_q & ~(done_o | timeout_o);
      cnt_q <= cnt_q + TW'(1);
    end
endmodule

// File: rtl/spi_cmd_master.sv
// spi_cmd_master: fetches SPI bytes from wb_spi, decodes host command frames and runs WB writes/reads.
module spi_cmd_master
  import spi_cmd_pkg::*;
#(
  parameter int                    ADDR_WIDTH  = 32,
  parameter int                    DATA_WIDTH  = 32,
  parameter logic [ADDR_WIDTH-1:0] SPI_BASE    = '0,
  parameter int                    ADDR_BYTES  = 2,
  parameter int                    DATA_BYTES  = 4,
  parameter int                    ACK_TIMEOUT = 255
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             spi_done_i,
  input  logic             ss_i,
  output logic             busy_o,
  output logic             frame_done_o,
  output logic             cmd_error_o,
  output logic             overrun_o,
  spi_cmd_master_if.master bus
);
  localparam int CW  = $clog2((ADDR_BYTES > DATA_BYTES ? ADDR_BYTES : DATA_BYTES) + 1);
  localparam int AW8 = ADDR_BYTES * 8;
  localparam int DW8 = DATA_BYTES * 8;
  state_t                state_q, state_d;
  phase_t                phase_q, phase_d;
  logic [CW-1:0]         cnt_q, cnt_d, tx_cnt_q, tx_cnt_d;
  logic [AW8-1:0]        addr_q, addr_d;
  logic [DW8-1:0]        data_q, data_d, tx_q, tx_d;
  logic [7:0]            rx_q, rx_d;
  logic [1:0]            ss_q;
  logic                  rd_q, rd_d, pend_q, pend_d, ovr_q, ovr_d, dis_q, dis_d;
  logic                  fd_q, fd_d, err_q, err_d;
  logic                  req, we, done, tmo, ss_s, cons, ovr_ev, abort, disc;
  logic [ADDR_WIDTH-1:0] wa;
  logic [DATA_WIDTH-1:0] wd;
  assign ss_s   = ss_q[1];
  assign cons   = (state_q == S_WAIT) & pend_q;
  assign ovr_ev = spi_done_i & pend_q & ~cons & ~ss_s;
  assign abort  = ss_s | ovr_ev;
  // A transaction still in flight after an abort runs to completion but its result is dropped
  assign disc   = dis_q | abort;
  assign busy_o       = (phase_q != P_CMD) | (state_q != S_WAIT);
  assign frame_done_o = fd_q;
  assign cmd_error_o  = err_q;
  assign overrun_o    = ovr_q;
  wb_master_port #(.ADDR_WIDTH(ADDR_WIDTH), .DATA_WIDTH(DATA_WIDTH), .ACK_TIMEOUT(ACK_TIMEOUT)) u_port (
    .clk, .rst, .req_i(req), .we_i(we), .addr_i(wa), .data_i(wd), .done_o(done), .timeout_o(tmo), .bus(bus)
  );
  always_comb begin
    state_d  = state_q;
    phase_d  = abort ? P_CMD : phase_q;
    cnt_d    = abort ? '0 : cnt_q;
    tx_cnt_d = abort ? '0 : tx_cnt_q;
    addr_d   = addr_q;
    data_d   = data_q;
    tx_d     = tx_q;
    rx_d     = rx_q;
    rd_d     = rd_q;
    pend_d   = ~ss_s & (spi_done_i | (pend_q & ~cons));
    ovr_d    = ovr_q | ovr_ev;
    dis_d    = disc;
    fd_d     = 1'b0;
    err_d    = 1'b0;
    req      = 1'b0;
    we       = 1'b0;
    wa       = SPI_BASE;
    wd       = '0;
    case (state_q)
      S_WAIT: if (pend_q && !ss_s) begin
        fd_d    = (phase_q == P_RESP) && (tx_cnt_q == '0);
        phase_d = fd_d ? P_CMD : phase_q;
        state_d = phase_q != P_RESP ? S_FETCH : (fd_d ? S_WAIT : S_TX_LOAD);
      end
      S_FETCH: begin
        req = 1'b1;
        if (done) begin
          rx_d    = bus.wbm_readdata[7:0];
          state_d = disc ? S_WAIT : S_PARSE;
        end
      end
      S_PARSE: begin
        state_d = S_WAIT;
        if (!disc)
          case (phase_q)
            P_CMD: begin
              phase_d = (rx_q == CMD_WRITE || rx_q == CMD_READ) ? P_ADDR : P_CMD;
              err_d   = rx_q != CMD_WRITE && rx_q != CMD_READ;
              rd_d    = rx_q == CMD_READ;
              cnt_d   = '0;
            end
            P_ADDR: begin
              addr_d = (addr_q << 8) | AW8'(rx_q);
              cnt_d  = cnt_q + CW'(1);
              if (cnt_q == CW'(ADDR_BYTES - 1)) begin
                cnt_d   = '0;
                phase_d = rd_q ? P_ADDR : P_DATA;
                state_d = rd_q ? S_TGT_RD : S_WAIT;
              end
            end
            P_DATA: begin
              data_d  = (data_q << 8) | DW8'(rx_q);
              cnt_d   = cnt_q == CW'(DATA_BYTES - 1) ? '0 : cnt_q + CW'(1);
              state_d = cnt_q == CW'(DATA_BYTES - 1) ? S_TGT_WR : S_WAIT;
            end
            default: ;
          endcase
      end
      S_TGT_WR: begin
        req = 1'b1;
        we  = 1'b1;
        wa  = ADDR_WIDTH'(addr_q);
        wd  = DATA_WIDTH'(data_q);
        if (done) begin
          state_d = S_WAIT;
          fd_d    = ~disc;
          phase_d = P_CMD;
        end
      end
      S_TGT_RD: begin
        req = 1'b1;
        wa  = ADDR_WIDTH'(addr_q);
        if (done) begin
          state_d  = disc ? S_WAIT : S_TX_LOAD;
          phase_d  = disc ? P_CMD : P_RESP;
          tx_d     = bus.wbm_readdata[DW8-1:0];
          tx_cnt_d = disc ? '0 : CW'(DATA_BYTES);
        end
      end
      S_TX_LOAD: begin
        req = 1'b1;
        we  = 1'b1;
        wd  = DATA_WIDTH'(tx_q[DW8-1 -: 8]);
        if (done) begin
          state_d  = S_WAIT;
          tx_d     = tx_q << 8;
          tx_cnt_d = disc ? '0 : tx_cnt_q - CW'(1);
        end
      end
      default: state_d = S_WAIT;
    endcase
    if (tmo) begin
      state_d = S_WAIT;
      phase_d = P_CMD;
      err_d   = 1'b1;
    end
    if (state_d == S_WAIT) dis_d = 1'b0;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q  <= S_WAIT;
      phase_q  <= P_CMD;
      cnt_q    <= '0;
      tx_cnt_q <= '0;
      addr_q   <= '0;
      data_q   <= '0;
      tx_q     <= '0;
      rx_q     <= '0;
      rd_q     <= 1'b0;
      pend_q   <= 1'b0;
      ovr_q    <= 1'b0;
      dis_q    <= 1'b0;
      fd_q     <= 1'b0;
      err_q    <= 1'b0;
      ss_q     <= 2'b11;
    end else begin
      state_q  <= state_d;
      phase_q  <= phase_d;
      cnt_q    <= cnt_d;
      tx_cnt_q <= tx_cnt_d;
      addr_q   <= addr_d;
      data_q   <= data_d;
      tx_q     <= tx_d;
      rx_q     <= rx_d;
      rd_q     <= rd_d;
      pend_q   <= pend_d;
      ovr_q    <= ovr_d;
      dis_q    <= dis_d;
      fd_q     <= fd_d;
      err_q    <= err_d;
      ss_q     <= {ss_q[0], ss_i};
    end
endmodule

// File: tb/tb_spi_cmd_master.sv
// tb_spi_cmd_master: wb_spi + WB memory model driving directed command frames into spi_cmd_master.
module tb_spi_cmd_master;
  logic clk = 1'b0, rst, spi_done_i, ss_i;
  logic busy_o, frame_done_o, cmd_error_o, overrun_o;
  logic [7:0]  spi_rx;
  logic [31:0] mem [256];
  logic [31:0] tw_addr, tw_data, tr_addr;
  logic [31:0] tx_log [$];
  int tgt_lat, wcnt, need, tw_cnt, tr_cnt, fd_cnt, err_cnt, run, max_run;
  int errors = 0, checks = 0;
  always #5 clk = ~clk;
  spi_cmd_master_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();
  spi_cmd_master dut (
    .clk, .rst, .spi_done_i, .ss_i, .busy_o, .frame_done_o, .cmd_error_o, .overrun_o, .bus(bus)
  );
  // wb_spi sits at address 0 and acks on the 2nd strobe cycle; target latency is tgt_lat (0 = never)
  initial begin
    bus.wbm_ack = 1'b0;
    bus.wbm_readdata = '0;
    {wcnt, tw_cnt, tr_cnt, fd_cnt, err_cnt, run, max_run} = '0;
    forever begin
      @(negedge clk);
      fd_cnt  += int'(frame_done_o);
      err_cnt += int'(cmd_error_o);
      if (bus.wbm_strobe) run++;
      else begin
        if (run > max_run) max_run = run;
        run = 0;
      end
      if (bus.wbm_ack) begin
        bus.wbm_ack = 1'b0;
        wcnt = 0;
      end else if (bus.wbm_strobe) begin
        wcnt++;
        need = (bus.wbm_address == 32'h0) ? 2 : tgt_lat;
        if (need != 0 && wcnt >= need) begin
          bus.wbm_ack = 1'b1;
          if (bus.wbm_address == 32'h0) begin
            if (bus.wbm_write) tx_log.push_back(bus.wbm_writedata);
            else bus.wbm_readdata = {24'h0, spi_rx};
          end else if (bus.wbm_write) begin
            mem[bus.wbm_address[7:0]] = bus.wbm_writedata;
            tw_cnt++;
            tw_addr = bus.wbm_address;
            tw_data = bus.wbm_writedata;
          end else begin
            bus.wbm_readdata = mem[bus.wbm_address[7:0]];
            tr_cnt++;
            tr_addr = bus.wbm_address;
          end
        end
      end else wcnt = 0;
    end
  end
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask
  task automatic wait_idle();
    int low = 0;
    for (int i = 0; i < 600 && low < 6; i++) begin
      @(posedge clk);
      #1 low = bus.wbm_strobe ? 0 : low + 1;
    end
    checks++;
    if (low < 6) begin
      errors++;
      $display("FAIL idle: strobe not idle within 600 cycles, required idle");
    end
  endtask
  task automatic pulse(input logic [7:0] b);
    spi_rx = b;
    spi_done_i = 1'b1;
    @(posedge clk);
    #1 spi_done_i = 1'b0;
  endtask
  task automatic send(input logic [7:0] b);
    pulse(b);
    wait_idle();
  endtask
  typedef struct {
    logic [55:0] b;
    int          n;
    int          lat;
    int          exp_wr;
    logic [31:0] exp_addr;
    logic [31:0] exp_data;
    int          exp_err;
  } vec_t;
  vec_t v [6];
  int w0, f0, e0, r0;
  initial begin
    v[0] = '{56'h010010DEADBEEF, 7, 1, 1, 32'h0010, 32'hDEADBEEF, 0};
    v[1] = '{56'h011234A55A00FF, 7, 3, 1, 32'h1234, 32'hA55A00FF, 0};
    v[2] = '{56'h7F000000000000, 1, 1, 0, 32'h0, 32'h0, 1};
    v[3] = '{56'h01001001020304, 7, 5, 1, 32'h0010, 32'h01020304, 0};
    v[4] = '{56'h00000000000000, 1, 1, 0, 32'h0, 32'h0, 1};
    v[5] = '{56'h01FFFFFFFFFFFF, 7, 2, 1, 32'hFFFF, 32'hFFFFFFFF, 0};
    rst = 1'b1; spi_done_i = 1'b0; ss_i = 1'b0; spi_rx = '0; tgt_lat = 1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_strobe", 32'(bus.wbm_strobe), 0);
    check("rst_cycle", 32'(bus.wbm_cycle), 0);
    check("rst_write", 32'(bus.wbm_write), 0);
    check("rst_addr", bus.wbm_address, 0);
    check("rst_wdata", bus.wbm_writedata, 0);
    check("rst_busy", 32'(busy_o), 0);
    check("rst_fd", 32'(frame_done_o), 0);
    check("rst_err", 32'(cmd_error_o), 0);
    check("rst_ovr", 32'(overrun_o), 0);
    rst = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    for (int i = 0; i < 6; i++) begin
      tgt_lat = v[i].lat; w0 = tw_cnt; f0 = fd_cnt; e0 = err_cnt; r0 = tr_cnt;
      for (int k = 0; k < v[i].n; k++) begin
        send(v[i].b[55-8*k -: 8]);
        if (k == 0 && v[i].exp_err == 0) check($sformatf("v%0d_busy_mid", i), 32'(busy_o), 1);
      end
      check($sformatf("v%0d_wr", i), tw_cnt - w0, v[i].exp_wr);
      check($sformatf("v%0d_fd", i), fd_cnt - f0, v[i].exp_wr);
      check($sformatf("v%0d_err", i), err_cnt - e0, v[i].exp_err);
      check($sformatf("v%0d_rd", i), tr_cnt - r0, 0);
      check($sformatf("v%0d_busy", i), 32'(busy_o), 0);
      if (v[i].exp_wr != 0) begin
        check($sformatf("v%0d_addr", i), tw_addr, v[i].exp_addr);
        check($sformatf("v%0d_data", i), tw_data, v[i].exp_data);
      end
    end
    // read frame: 0x12 preloaded right after the target read, one more byte per dummy
    mem[8'h20] = 32'h12345678; tgt_lat = 3; tx_log.delete(); r0 = tr_cnt; f0 = fd_cnt;
    send(8'h02); send(8'h00); send(8'h20);
    check("rd_cnt", tr_cnt - r0, 1);
    check("rd_addr", tr_addr, 32'h20);
    check("rd_pre_n", tx_log.size(), 1);
    check("rd_b0", tx_log[0], 32'h12);
    repeat (3) send(8'hAA);
    check("rd_n", tx_log.size(), 4);
    check("rd_b1", tx_log[1], 32'h34);
    check("rd_b2", tx_log[2], 32'h56);
    check("rd_b3", tx_log[3], 32'h78);
    check("rd_fd_early", fd_cnt - f0, 0);
    send(8'hAA);
    check("rd_fd", fd_cnt - f0, 1);
    check("rd_n_end", tx_log.size(), 4);
    check("rd_busy", 32'(busy_o), 0);
    // ss deasserted mid-frame discards it; the next frame is decoded from its command byte
    tgt_lat = 1; w0 = tw_cnt; f0 = fd_cnt;
    send(8'h01); send(8'h00); send(8'h10);
    ss_i = 1'b1;
    repeat (5) @(posedge clk);
    #1 check("ss_busy", 32'(busy_o), 0);
    ss_i = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    foreach (v[0].b[i]) ;
    send(8'h01); send(8'h00); send(8'h30); send(8'hCA); send(8'hFE); send(8'hBA); send(8'hBE);
    check("ss_wr", tw_cnt - w0, 1);
    check("ss_fd", fd_cnt - f0, 1);
    check("ss_addr", tw_addr, 32'h30);
    check("ss_data", tw_data, 32'hCAFEBABE);
    // target never acks: strobe held exactly 255 cycles, then error and recovery
    tgt_lat = 0; max_run = 0; w0 = tw_cnt; f0 = fd_cnt; e0 = err_cnt;
    send(8'h01); send(8'h00); send(8'h40); send(8'h11); send(8'h22); send(8'h33); send(8'h44);
    check("to_run", max_run, 255);
    check("to_err", err_cnt - e0, 1);
    check("to_fd", fd_cnt - f0, 0);
    check("to_wr", tw_cnt - w0, 0);
    check("to_busy", 32'(busy_o), 0);
    tgt_lat = 2; w0 = tw_cnt;
    send(8'h01); send(8'h00); send(8'h44); send(8'h55); send(8'h66); send(8'h77); send(8'h88);
    check("to_rec_wr", tw_cnt - w0, 1);
    check("to_rec_data", tw_data, 32'h55667788);
    // two spi_done while the target read stalls: overrun, frame dropped, reset clears
    tgt_lat = 20; tx_log.delete(); f0 = fd_cnt;
    send(8'h02); send(8'h00); pulse(8'h20);
    repeat (10) @(posedge clk);
    #1 pulse(8'hAA);
    repeat (2) @(posedge clk);
    #1 pulse(8'hAA);
    repeat (2) @(posedge clk);
    #1 check("ovr_set", 32'(overrun_o), 1);
    wait_idle();
    check("ovr_sticky", 32'(overrun_o), 1);
    check("ovr_no_tx", tx_log.size(), 0);
    check("ovr_no_fd", fd_cnt - f0, 0);
    rst = 1'b1;
    #2 check("ovr_rst", 32'(overrun_o), 0);
    check("ovr_rst_busy", 32'(busy_o), 0);
    @(posedge clk);
    #1 rst = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    tgt_lat = 1; w0 = tw_cnt;
    send(8'h01); send(8'h00); send(8'h10); send(8'h00); send(8'h00); send(8'h00); send(8'h05);
    check("post_rst_wr", tw_cnt - w0, 1);
    check("post_rst_data", tw_data, 32'h00000005);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
